// File: rtl/pipe_stage_chain_if.sv
// pipe_stage_chain_if
// Handshake bundle for pipe_stage_chain.
//   flush                : synchronous clear of every stage
//   in_valid/in_ready    : upstream offer / chain accept
//   in_data              : upstream payload (WIDTH bits)
//   out_valid/out_ready  : chain offer / downstream accept
//   out_data             : payload of the last stage
//   count                : number of occupied stages
// Modports: master = upstream/downstream environment, slave = the chain.
interface pipe_stage_chain_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) ();
  logic                       flush;
  logic                       in_valid;
  logic                       in_ready;
  logic [WIDTH-1:0]           in_data;
  logic                       out_valid;
  logic                       out_ready;
  logic [WIDTH-1:0]           out_data;
  logic [$clog2(DEPTH+1)-1:0] count;

  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count
  );

  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count
  );
endinterface

// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain
// Bubble-collapsing chain of DEPTH payload registers with valid/ready at both
// ends. Each stage advances whenever it is empty or the stage after it is
// advancing, so empty slots fill even while the output is stalled.
// Ports:
//   clk    : clock, all state updates on the rising edge
//   rst_n  : asynchronous active-low reset (all stages empty, data RST_VAL)
//   bus    : pipe_stage_chain_if.slave (flush, in/out handshakes, count)
module pipe_stage_chain #(
  parameter int              WIDTH   = 16,
  parameter int              DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  pipe_stage_chain_if.slave bus
);

  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0] v;
  logic [WIDTH-1:0] d     [DEPTH];
  logic [DEPTH-1:0] src_v;
  logic [WIDTH-1:0] src_d [DEPTH];
  logic [DEPTH-1:0] v_nxt;
  logic [DEPTH:0]   r;
  logic             in_ready_i;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_nxt;

  // Ready ripples from the output end back to the input end; a stage can
  // take new data if it is empty or its own content is moving on.
  always_comb begin
    r        = '0;
    r[DEPTH] = bus.out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      r[i] = ~v[i] | r[i+1];
    end
  end

  // rst_n is folded in so in_ready reads low while reset is held.
  assign in_ready_i = r[0] & ~bus.flush & rst_n;

  always_comb begin
    src_v = '0;
    for (int i = 0; i < DEPTH; i++) begin
      src_d[i] = '0;
    end
    src_v[0] = bus.in_valid & in_ready_i;
    src_d[0] = bus.in_data;
    for (int i = 1; i < DEPTH; i++) begin
      src_v[i] = v[i-1];
      src_d[i] = d[i-1];
    end
  end

  // Next valid vector, used only to keep count registered alongside v.
  always_comb begin
    v_nxt     = '0;
    count_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      v_nxt[i]  = bus.flush ? 1'b0 : (r[i] ? src_v[i] : v[i]);
      count_nxt = count_nxt + CW'(v_nxt[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v       <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        d[i] <= RST_VAL;
      end
    end else if (bus.flush) begin
      v       <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        d[i] <= RST_VAL;
      end
    end else begin
      count_q <= count_nxt;
      for (int i = 0; i < DEPTH; i++) begin
        if (r[i]) begin
          v[i] <= src_v[i];
          d[i] <= src_d[i];
        end
      end
    end
  end

  assign bus.in_ready  = in_ready_i;
  assign bus.out_valid = v[DEPTH-1] & ~bus.flush;
  assign bus.out_data  = d[DEPTH-1];
  assign bus.count     = count_q;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// tb_pipe_stage_chain
// Directed bench for pipe_stage_chain (WIDTH=16, DEPTH=3). Accepted inputs are
// pushed to a scoreboard queue; every output transfer pops and compares.
module tb_pipe_stage_chain;

  localparam int WIDTH = 16;
  localparam int DEPTH = 3;

  logic clk;
  logic rst_n;

  pipe_stage_chain_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  pipe_stage_chain #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .RST_VAL (16'h0000)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1, "watchdog");
  end

  logic [WIDTH-1:0] q[$];
  int n_vec    = 0;
  int n_err    = 0;
  int cyc      = 0;
  int acc_cyc  = -1;
  int lat_cyc  = -1;
  int first1   = -1;
  int last8    = -1;
  int pop_last = -1;
  int pop_prev = -1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp)
    else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Sample on the falling edge, update the model, then step past the next
  // rising edge.
  task automatic cycle();
    logic [WIDTH-1:0] exp;
    @(negedge clk);
    chk("count_vs_model", 32'(bus.count), 32'(q.size()));
    if (bus.out_valid && bus.out_ready) begin
      chk("out_nonempty", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        exp = q.pop_front();
        chk("out_data", 32'(bus.out_data), 32'(exp));
        pop_prev = pop_last;
        pop_last = cyc;
        if (exp == 16'h1234) lat_cyc = cyc;
        if (exp == 16'h0001) first1 = cyc;
        if (exp == 16'h0008) last8 = cyc;
      end
    end
    if (bus.in_valid && bus.in_ready) begin
      q.push_back(bus.in_data);
      if (bus.in_data == 16'h1234) acc_cyc = cyc;
    end
    if (bus.flush) q.delete();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic drain();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 20 && q.size() != 0; k++) cycle();
    chk("drain_done", 32'(q.size()), 32'd0);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;

    // Reset values
    #12;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd0);
    chk("rst_out_data",  32'(bus.out_data),  32'h0000);
    chk("rst_count",     32'(bus.count),     32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    cyc++;
    #1;
    chk("empty_in_ready", 32'(bus.in_ready), 32'd1);

    // Single entry latency
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h1234;
    cycle();
    bus.in_valid = 1'b0;
    drain();
    chk("latency", 32'(lat_cyc - acc_cyc), 32'd3);

    // Sustained streaming
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 16'(i);
      cycle();
      if (i >= 3) chk("stream_count", 32'(bus.count), 32'd3);
    end
    drain();
    chk("stream_no_gap", 32'(last8 - first1), 32'd7);

    // Backpressure until full, then simultaneous in/out
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 16'hA000; cycle();
    bus.in_data   = 16'hA001; cycle();
    bus.in_data   = 16'hA002; cycle();
    bus.in_data   = 16'hA003;
    chk("full_count",    32'(bus.count),    32'd3);
    chk("full_in_ready", 32'(bus.in_ready), 32'd0);
    cycle();
    bus.out_ready = 1'b1;
    #1;
    chk("full_pass_in_ready", 32'(bus.in_ready),  32'd1);
    chk("full_out_valid",     32'(bus.out_valid), 32'd1);
    chk("full_out_data",      32'(bus.out_data),  32'hA000);
    cycle();
    chk("swap_count", 32'(bus.count), 32'd3);
    drain();

    // Bubble collapse under backpressure
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1; bus.in_data = 16'hB000; cycle();
    bus.in_valid  = 1'b0;                         cycle();
    bus.in_valid  = 1'b1; bus.in_data = 16'hB001; cycle();
    bus.in_valid  = 1'b0;                         cycle();
    chk("bubble_count",     32'(bus.count),     32'd2);
    chk("bubble_out_valid", 32'(bus.out_valid), 32'd1);
    drain();
    chk("bubble_back2back", 32'(pop_last - pop_prev), 32'd1);

    // Flush with a full chain and an offered input
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 16'hD000; cycle();
    bus.in_data   = 16'hD001; cycle();
    bus.in_data   = 16'hD002; cycle();
    chk("pre_flush_count", 32'(bus.count), 32'd3);
    bus.flush     = 1'b1;
    bus.in_data   = 16'hC000;
    bus.out_ready = 1'b1;
    #1;
    chk("flush_in_ready",  32'(bus.in_ready),  32'd0);
    chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
    cycle();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("post_flush_count",     32'(bus.count),     32'd0);
    chk("post_flush_out_data",  32'(bus.out_data),  32'h0000);
    chk("post_flush_out_valid", 32'(bus.out_valid), 32'd0);
    chk("post_flush_in_ready",  32'(bus.in_ready),  32'd1);
    for (int k = 0; k < 5; k++) cycle();

    // Asynchronous reset mid-stream
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 16'hE000; cycle();
    bus.in_data   = 16'hE001; cycle();
    bus.in_valid  = 1'b0;
    chk("pre_rst_count", 32'(bus.count), 32'd2);
    bus.out_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_in_ready",  32'(bus.in_ready),  32'd0);
    chk("arst_out_data",  32'(bus.out_data),  32'h0000);
    chk("arst_count",     32'(bus.count),     32'd0);
    q.delete();
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    cyc++;
    #1;
    chk("post_rst_count",     32'(bus.count),     32'd0);
    chk("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("post_rst_in_ready",  32'(bus.in_ready),  32'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'hF000;
    cycle();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
